// File: rtl/spi_cmd_responder.sv
// SPI slave + command decoder: 32-bit {cmd, addr, data} frames, committed on latch_data_n fall.
// Define SPI_RESP_ECHO_EN to echo {CMD_READ, addr} in the upper half of read responses.
module spi_cmd_responder #(
  parameter int         ADDR_W      = 8,
  parameter int         DATA_W      = 16,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CMD_WRITE   = 8'h02,
  parameter logic [7:0] CMD_READ    = 8'h01
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  input  logic              latch_data_n,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
  output logic              cmd_err,
  output logic [2:0]        state_dbg
);

  localparam int FRAME_W = 8 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, WRITE, READ, LOAD} state_t;

  // Top bit of each chain is the previous synchronised value, used for edge detection.
  logic [SYNC_STAGES:0]   sclk_sr, ss_sr, latch_sr;
  logic [SYNC_STAGES-1:0] mosi_sr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sr  <= '0;
      ss_sr    <= '1;
      latch_sr <= '1;
      mosi_sr  <= '0;
    end else begin
      sclk_sr  <= {sclk_sr[SYNC_STAGES-1:0], sclk};
      ss_sr    <= {ss_sr[SYNC_STAGES-1:0], ss_n};
      latch_sr <= {latch_sr[SYNC_STAGES-1:0], latch_data_n};
      mosi_sr  <= SYNC_STAGES'({mosi_sr, mosi});
    end
  end

  logic sclk_rise, sclk_fall, ss_rise, ss_fall, ss_sel, latch_fall, mosi_s;
  assign sclk_rise  =  sclk_sr[SYNC_STAGES-1] & ~sclk_sr[SYNC_STAGES];
  assign sclk_fall  = ~sclk_sr[SYNC_STAGES-1] &  sclk_sr[SYNC_STAGES];
  assign ss_rise    =  ss_sr[SYNC_STAGES-1]   & ~ss_sr[SYNC_STAGES];
  assign ss_fall    = ~ss_sr[SYNC_STAGES-1]   &  ss_sr[SYNC_STAGES];
  assign ss_sel     = ~ss_sr[SYNC_STAGES-1];
  assign latch_fall = ~latch_sr[SYNC_STAGES-1] & latch_sr[SYNC_STAGES];
  assign mosi_s     = mosi_sr[SYNC_STAGES-1];

  state_t             state;
  logic [FRAME_W-1:0] rx, shadow, tx;
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_valid;

  logic [7:0]        sh_cmd;
  logic [ADDR_W-1:0] sh_addr;
  logic [DATA_W-1:0] sh_data;
  assign sh_cmd  = shadow[FRAME_W-1 -: 8];
  assign sh_addr = shadow[DATA_W +: ADDR_W];
  assign sh_data = shadow[DATA_W-1:0];

  // Register port: reg_we/reg_re are single-cycle strobes qualified by reg_addr (and
  // reg_wdata) in the same cycle; reg_rdata must be valid the cycle after reg_re.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rx          <= '0;
      shadow      <= '0;
      tx          <= '0;
      bit_cnt     <= '0;
      frame_valid <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      frame_err   <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      frame_err <= 1'b0;
      cmd_err   <= 1'b0;

      if (ss_fall) begin
        bit_cnt <= '0;
      end else if (ss_sel && sclk_rise && bit_cnt != FULL_CNT) begin
        rx      <= {rx[FRAME_W-2:0], mosi_s};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (ss_sel && sclk_fall) tx <= {tx[FRAME_W-2:0], 1'b0};

      if (ss_rise) begin
        bit_cnt <= '0;
        tx      <= '0;
        if (bit_cnt == FULL_CNT) begin
          shadow      <= rx;
          frame_valid <= 1'b1;
        end else begin
          frame_err   <= 1'b1;
          frame_valid <= 1'b0;
        end
      end

      case (state)
        IDLE:  if (ss_fall) state <= SHIFT;
        SHIFT: if (ss_rise) state <= (bit_cnt == FULL_CNT) ? HOLD : IDLE;
        HOLD: begin
          // A new frame always wins over a simultaneous latch strobe.
          if (ss_fall) begin
            state       <= SHIFT;
            frame_valid <= 1'b0;
          end else if (latch_fall && frame_valid) begin
            if (sh_cmd == CMD_WRITE) begin
              state       <= WRITE;
              reg_addr    <= sh_addr;
              reg_wdata   <= sh_data;
              reg_we      <= 1'b1;
              frame_valid <= 1'b0;
            end else if (sh_cmd == CMD_READ) begin
              state    <= READ;
              reg_addr <= sh_addr;
              reg_re   <= 1'b1;
            end else begin
              state       <= IDLE;
              cmd_err     <= 1'b1;
              frame_valid <= 1'b0;
            end
          end
        end
        WRITE: state <= IDLE;
        READ:  state <= LOAD;
        LOAD: begin
`ifdef SPI_RESP_ECHO_EN
          tx <= {CMD_READ, reg_addr, reg_rdata};
`else
          tx <= {{(FRAME_W-DATA_W){1'b0}}, reg_rdata};
`endif
          frame_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso      = tx[FRAME_W-1];
  assign miso_oe   = ss_sel;
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Directed bench for spi_cmd_responder: vector table plus hand sequences for
// coincident latch/select and mid-frame reset.
module tb_spi_cmd_responder;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd2;
`ifdef SPI_RESP_ECHO_EN
  localparam logic [31:0] RESP_F = 32'h0104_000F;
  localparam logic [31:0] RESP_B = 32'h0110_BEEF;
`else
  localparam logic [31:0] RESP_F = 32'h0000_000F;
  localparam logic [31:0] RESP_B = 32'h0000_BEEF;
`endif

  logic        clock = 1'b0;
  logic        reset_n, sclk, mosi, ss_n, latch_data_n;
  logic        miso, miso_oe, reg_we, reg_re, frame_err, cmd_err;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata = '0;
  logic [2:0]  state_dbg;
  logic [15:0] mem [256];

  int n_vec  = 0;
  int n_fail = 0;
  int we_cnt = 0, re_cnt = 0, ferr_cnt = 0, cerr_cnt = 0;

  always #5 clock = ~clock;

  spi_cmd_responder dut (
    .clock(clock), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .latch_data_n(latch_data_n), .miso(miso), .miso_oe(miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_err(frame_err), .cmd_err(cmd_err),
    .state_dbg(state_dbg)
  );

  // Register file model: write on reg_we, registered read one cycle after reg_re.
  always @(posedge clock) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= mem[reg_addr];
  end

  always @(negedge clock) begin
    if (reg_we)    we_cnt++;
    if (reg_re)    re_cnt++;
    if (frame_err) ferr_cnt++;
    if (cmd_err)   cerr_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic latch_pulse();
    latch_data_n = 1'b0;
    wait_cyc(8);
    latch_data_n = 1'b1;
    wait_cyc(8);
  endtask

  // Master: mosi changes on sclk fall, miso sampled just before sclk rise.
  task automatic spi_frame(input logic [31:0] data, input int nbits, input bit latch_with_ss,
                           output logic [31:0] rx_word, output logic oe_mid);
    rx_word = '0;
    @(negedge clock);
    ss_n = 1'b0;
    if (latch_with_ss) latch_data_n = 1'b0;
    wait_cyc(8);
    latch_data_n = 1'b1;
    oe_mid = miso_oe;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 32) ? data[31-i] : 1'b1;
      wait_cyc(8);
      if (i < 32) rx_word[31-i] = miso;
      sclk = 1'b1;
      wait_cyc(8);
      sclk = 1'b0;
    end
    wait_cyc(8);
    ss_n = 1'b1;
    wait_cyc(8);
  endtask

  typedef struct {
    bit          send;
    logic [31:0] frame;
    int          nbits;
    int          latches;
    int          e_we, e_re, e_ferr, e_cerr;
    logic [7:0]  e_addr;
    logic [15:0] e_wdata;
    logic [31:0] e_miso;
    logic [2:0]  e_state;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] word;
    logic        oe;
    int          we0, re0, fe0, ce0;

    vecs[0]  = '{0, 32'h0000_0000,  0, 1, 0, 0, 0, 0, 8'h00, 16'h0000, 32'h0, S_IDLE};
    vecs[1]  = '{1, 32'h0202_0008, 32, 1, 1, 0, 0, 0, 8'h02, 16'h0008, 32'h0, S_IDLE};
    vecs[2]  = '{1, 32'h0204_000F, 32, 1, 1, 0, 0, 0, 8'h04, 16'h000F, 32'h0, S_IDLE};
    vecs[3]  = '{1, 32'h0104_0000, 32, 1, 0, 1, 0, 0, 8'h04, 16'h000F, 32'h0, S_IDLE};
    vecs[4]  = '{1, 32'h0000_0000, 32, 0, 0, 0, 0, 0, 8'h04, 16'h000F, RESP_F, S_HOLD};
    vecs[5]  = '{1, 32'h02AA_B000, 20, 1, 0, 0, 1, 0, 8'h04, 16'h000F, 32'h0, S_IDLE};
    vecs[6]  = '{1, 32'h0705_1234, 32, 1, 0, 0, 0, 1, 8'h04, 16'h000F, 32'h0, S_IDLE};
    vecs[7]  = '{1, 32'h0210_BEEF, 32, 2, 1, 0, 0, 0, 8'h10, 16'hBEEF, 32'h0, S_IDLE};
    vecs[8]  = '{1, 32'h0110_0000, 32, 1, 0, 1, 0, 0, 8'h10, 16'hBEEF, 32'h0, S_IDLE};
    vecs[9]  = '{1, 32'h0220_1357, 36, 0, 0, 0, 0, 0, 8'h10, 16'hBEEF, RESP_B, S_HOLD};
    vecs[10] = '{0, 32'h0000_0000,  0, 1, 1, 0, 0, 0, 8'h20, 16'h1357, 32'h0, S_IDLE};

    for (int a = 0; a < 256; a++) mem[a] = '0;
    reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1; latch_data_n = 1'b1;
    wait_cyc(3);
    check("rst miso",      32'(miso),      32'h0);
    check("rst miso_oe",   32'(miso_oe),   32'h0);
    check("rst reg_addr",  32'(reg_addr),  32'h0);
    check("rst reg_wdata", 32'(reg_wdata), 32'h0);
    check("rst strobes",   {28'h0, reg_we, reg_re, frame_err, cmd_err}, 32'h0);
    check("rst state",     32'(state_dbg), 32'(S_IDLE));
    reset_n = 1'b1;
    wait_cyc(5);

    for (int v = 0; v < 11; v++) begin
      we0 = we_cnt; re0 = re_cnt; fe0 = ferr_cnt; ce0 = cerr_cnt;
      word = '0; oe = 1'b0;
      if (vecs[v].send) spi_frame(vecs[v].frame, vecs[v].nbits, 1'b0, word, oe);
      for (int k = 0; k < vecs[v].latches; k++) latch_pulse();
      wait_cyc(8);
      check($sformatf("v%0d reg_we", v),    32'(we_cnt - we0),   32'(vecs[v].e_we));
      check($sformatf("v%0d reg_re", v),    32'(re_cnt - re0),   32'(vecs[v].e_re));
      check($sformatf("v%0d frame_err", v), 32'(ferr_cnt - fe0), 32'(vecs[v].e_ferr));
      check($sformatf("v%0d cmd_err", v),   32'(cerr_cnt - ce0), 32'(vecs[v].e_cerr));
      check($sformatf("v%0d reg_addr", v),  32'(reg_addr),  32'(vecs[v].e_addr));
      check($sformatf("v%0d reg_wdata", v), 32'(reg_wdata), 32'(vecs[v].e_wdata));
      check($sformatf("v%0d state", v),     32'(state_dbg), 32'(vecs[v].e_state));
      check($sformatf("v%0d oe idle", v),   32'(miso_oe),   32'h0);
      if (vecs[v].send) begin
        check($sformatf("v%0d miso word", v), word, vecs[v].e_miso);
        check($sformatf("v%0d oe in frame", v), 32'(oe), 32'h1);
      end
    end

    // Latch falling together with ss_n while a frame is held: the frame is dropped silently.
    we0 = we_cnt; ce0 = cerr_cnt;
    spi_frame(32'h0244_1111, 32, 1'b0, word, oe);
    check("coinc held state", 32'(state_dbg), 32'(S_HOLD));
    spi_frame(32'h0255_2222, 32, 1'b1, word, oe);
    check("coinc no write", 32'(we_cnt - we0), 32'h0);
    check("coinc state", 32'(state_dbg), 32'(S_HOLD));
    latch_pulse();
    wait_cyc(8);
    check("coinc write", 32'(we_cnt - we0), 32'h1);
    check("coinc addr",  32'(reg_addr),  32'h55);
    check("coinc wdata", 32'(reg_wdata), 32'h2222);
    check("coinc no cmd_err", 32'(cerr_cnt - ce0), 32'h0);

    // Reset after 16 bits of a frame, then a clean write.
    we0 = we_cnt; re0 = re_cnt; fe0 = ferr_cnt; ce0 = cerr_cnt;
    ss_n = 1'b0;
    wait_cyc(8);
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      wait_cyc(8);
      sclk = 1'b1;
      wait_cyc(8);
      sclk = 1'b0;
    end
    check("midrst state before", 32'(state_dbg), 32'h1);
    reset_n = 1'b0;
    wait_cyc(2);
    check("midrst state", 32'(state_dbg), 32'(S_IDLE));
    check("midrst reg_addr", 32'(reg_addr), 32'h0);
    check("midrst reg_wdata", 32'(reg_wdata), 32'h0);
    check("midrst miso_oe", 32'(miso_oe), 32'h0);
    check("midrst miso", 32'(miso), 32'h0);
    ss_n = 1'b1; sclk = 1'b0;
    wait_cyc(4);
    reset_n = 1'b1;
    wait_cyc(8);
    check("midrst no pulses", 32'((we_cnt - we0) + (re_cnt - re0) + (ferr_cnt - fe0) + (cerr_cnt - ce0)), 32'h0);
    spi_frame(32'h0233_A5A5, 32, 1'b0, word, oe);
    latch_pulse();
    wait_cyc(8);
    check("postrst write", 32'(we_cnt - we0), 32'h1);
    check("postrst addr",  32'(reg_addr),  32'h33);
    check("postrst wdata", 32'(reg_wdata), 32'hA5A5);
    check("postrst ferr",  32'(ferr_cnt - fe0), 32'h0);
    check("postrst state", 32'(state_dbg), 32'(S_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_responder.md
Name: spi_cmd_responder

Overview:
- SPI slave and command decoder inside the user project; it is the chip-side end of the external 32-bit SPI control link.
- Deserialises frames {cmd[7:0], addr[7:0], data[15:0]}, MSB first, from an external master.
- On an active-low latch strobe it commits a write or read to the internal register file.
- For a read, it returns the read data on miso during the next frame.
- All SPI pins are asynchronous to `clock` and are oversampled.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 16, register data width; frame width = 8 + ADDR_W + DATA_W = 32.
- SYNC_STAGES, 2, flip-flop stages on each async input (sclk, mosi, ss_n, latch_data_n).
- CMD_WRITE, 8'h02, write opcode.
- CMD_READ, 8'h01, read opcode.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- sclk  in  1  SPI clock from pad, idle low, async.
- mosi  in  1  SPI data in, async; master changes it on sclk fall.
- ss_n  in  1  SPI select, active low, async.
- latch_data_n  in  1  commit strobe, active low, async.
- miso  out  1  SPI data out; master samples it on sclk rise.
- miso_oe  out  1  pad output enable; high while synchronised ss_n is low.
- reg_addr  out  ADDR_W  register address.
- reg_wdata  out  DATA_W  write data.
- reg_we  out  1  one-cycle write pulse.
- reg_re  out  1  one-cycle read pulse.
- reg_rdata  in  DATA_W  read data; valid the cycle after reg_re.
- frame_err  out  1  one-cycle pulse: frame aborted with bit count != 32.
- cmd_err  out  1  one-cycle pulse: commit attempted with an unknown opcode.

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_err=0, cmd_err=0. Shift registers, bit counter, frame_valid and tx register are cleared. Sync chains reset to idle: sclk=0, ss_n=1, latch_data_n=1.
- Edge detection: sclk rise and fall, ss_n rise and fall, latch fall are detected on synchronised signals. Latency from pin to detection is SYNC_STAGES+1 cycles.
- Timing requirement: each sclk half-period must be at least SYNC_STAGES+2 clock cycles. The bench uses 8 cycles.
- Receive: on ss_n fall, bit counter is set to 0. Each sclk rise while ss_n is low shifts mosi into rx[0] and increments the counter, saturating at 32. Bits beyond 32 are ignored.
- Frame end (ss_n rise):
  - count == 32: the frame is copied to the shadow register and frame_valid is set.
  - otherwise: frame_err pulses and frame_valid is cleared.
  - In both cases the counter is reset and tx is cleared to 0.
- Transmit: miso = tx[31], registered. Each detected sclk fall while ss_n is low shifts tx left by 1, filling with 0. There is no shift before the first rise, so bit 31 is presented as soon as ss_n falls.
- FSM states: IDLE, SHIFT, HOLD, WRITE, READ, LOAD.
  - IDLE -> SHIFT on ss_n fall.
  - SHIFT -> HOLD on ss_n rise with a valid frame; SHIFT -> IDLE on an aborted frame.
  - HOLD -> WRITE or READ on latch fall, by opcode.
  - HOLD -> IDLE with cmd_err on latch fall with an unknown opcode.
  - HOLD -> SHIFT on a new ss_n fall; the held frame is discarded with no error.
  - WRITE: reg_addr and reg_wdata driven from shadow; reg_we=1 for one cycle; -> IDLE.
  - READ: reg_addr driven, reg_re=1 for one cycle; -> LOAD.
  - LOAD: tx <= {16'h0000, reg_rdata}; frame_valid cleared; -> IDLE.
- reg_addr and reg_wdata hold their last values between accesses.
- A latch fall in IDLE or SHIFT is ignored: no access, no error.
- A latch fall coincident with an ss_n fall: ss_n wins and the latch is ignored.
- Each frame commits at most once; a second latch with no new frame is ignored.
- Reset mid-frame returns the block to IDLE immediately, with no pulses.

Optional Feature:
- SPI_RESP_ECHO_EN defined: LOAD writes tx <= {CMD_READ, reg_addr, reg_rdata}, so the response frame echoes the command and address in its upper 16 bits.
- Undefined: the upper 16 bits of the response are 0.
- The lower 16 bits are identical either way.

Test Plan:
- Write frame 32'h02_02_0008, then latch low -> exactly one reg_we pulse with reg_addr=8'h02, reg_wdata=16'h0008; no reg_re.
- Read frame 32'h01_04_0000, latch, reg_rdata=16'h000F, then a second frame of 32'h0 -> miso yields 32'h0000_000F. With SPI_RESP_ECHO_EN the result is 32'h0104_000F.
- Raise ss_n after 20 bits -> one frame_err pulse; a subsequent latch produces no reg_we or reg_re.
- Frame with opcode 8'h07, then latch -> one cmd_err pulse; no register access; FSM returns to IDLE.
- Valid write frame, latch twice -> one reg_we only. A latch before any frame -> no activity.
- Assert reset_n low mid-frame (after 16 bits), release, then send a full write frame -> outputs reset to 0 and the new frame decodes correctly.
